iram_loader: RTL and testbench
==============================

Name: iram_loader

Overview:
- Upstream boot stage for the single-core processor. It collects 4-bit nibbles from the board input switches, assembles them into 16-bit instruction words, and writes those words sequentially into the instruction memory (IRAM) from address 0.
- When loading finishes it asserts core_run, which releases the control unit to start fetching from PC = 0.
- It owns the IRAM write port only while loading; the core owns the read port.

Parameters:
- DATA_W, 16, width of an IRAM word.
- ADDR_W, 16, width of the IRAM address; matches the PC width.
- NIB_W, 4, width of one input nibble. DATA_W/NIB_W must be an integer; default gives 4 nibbles per word.
- DEPTH, 256, number of writable IRAM words. Addresses run 0..DEPTH-1.
- END_WORD, 16'hFFFF, terminator word. It is never written to IRAM.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_load  input  1  level-sampled request to begin (or restart) a load.
- nib_in  input  NIB_W  nibble data from the switches.
- nib_valid  input  1  nib_in holds a valid nibble.
- nib_ready  output  1  loader can accept a nibble this cycle.
- mem_wr_en  output  1  one-cycle IRAM write strobe.
- mem_addr  output  ADDR_W  IRAM write address.
- mem_wdata  output  DATA_W  IRAM write data.
- core_run  output  1  releases the control unit; high only in DONE.
- word_count  output  ADDR_W  number of words written in the current or last load.
- overflow  output  1  sticky flag: the load hit DEPTH before END_WORD arrived.

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE.
  - nib_ready, mem_wr_en, core_run and overflow all 0.
  - mem_addr, mem_wdata and word_count all 0.
  - Nibble shift register and nibble counter both 0.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - nib_ready = 0.
  - On start_load = 1, go to COLLECT next cycle; clear mem_addr, word_count, overflow and the nibble counter.
- COLLECT:
  - nib_ready = 1.
  - A nibble is accepted when nib_valid and nib_ready are both 1 on a rising edge.
  - Nibbles arrive MSB-first: shift register = {shift[DATA_W-NIB_W-1:0], nib_in}.
  - The nibble counter counts 0..3 and wraps to 0 on the 4th accept.
  - On the 4th accept, the assembled word is evaluated:
    - If the word equals END_WORD, go to DONE. No write; word_count is unchanged.
    - Otherwise, go to WRITE with mem_wdata = the assembled word.
  - nib_valid while nib_ready = 0 is ignored; the source must hold the nibble.
- WRITE:
  - Exactly one cycle: nib_ready = 0, mem_wr_en = 1, with mem_addr and mem_wdata stable.
  - Next cycle: mem_addr and word_count each increment by 1.
    - If the new mem_addr equals DEPTH, set overflow = 1 and go to DONE.
    - Otherwise, return to COLLECT.
  - Latency: the last nibble accepted at edge N gives mem_wr_en high in cycle N+1.
- DONE:
  - core_run = 1, nib_ready = 0.
  - mem_addr holds its last value; mem_wr_en = 0.
  - On start_load = 1: core_run drops on the next edge, all counters and overflow clear, and the FSM goes to COLLECT (reload).
- start_load while in COLLECT or WRITE is ignored; there is no mid-load restart except via reset.
- Reset asserted mid-load: immediate return to IDLE. A write strobe already in flight is cut off asynchronously. A partially assembled word is discarded.
- mem_wr_en and core_run are never high in the same cycle.
- Width rules:
  - word_count saturates naturally at DEPTH; it cannot exceed it because of the overflow exit.
  - The mem_addr increment is ADDR_W wide; DEPTH must be at most 2^ADDR_W.

Decomposition:
- Shared package (loader_pkg): state encoding constants (IDLE = 2'd0, COLLECT = 2'd1, WRITE = 2'd2, DONE = 2'd3) and the END_WORD default. The control unit and top level reuse END_WORD.
- One natural sub-module: nibble_packer. It holds the shift register and the 2-bit nibble counter, with inputs clk, reset, clear, shift_en and nib_in, and outputs word and word_full. The FSM, address counter and flags stay in iram_loader.

Test Plan:
1. Reset asserted mid-COLLECT after 2 nibbles -> all outputs return to 0 immediately. A following start_load plus nibbles 1,2,3,4 writes 16'h1234 to address 0 (no stale nibbles).
2. start_load, then nibbles 1,2,3,4 then A,B,C,D then F,F,F,F -> writes 16'h1234 @0 and 16'hABCD @1, each with a single-cycle mem_wr_en one cycle after the 4th nibble. Then core_run = 1, word_count = 2, overflow = 0, and 16'hFFFF is never written.
3. nib_valid held high continuously during WRITE cycles -> nib_ready = 0 there, no nibble is lost or duplicated, and the word sequence is exact.
4. DEPTH = 4, feed 5 non-terminator words -> 4 writes at addresses 0..3, then DONE with overflow = 1, word_count = 4, core_run = 1; the 5th word is never accepted (nib_ready = 0).
5. In DONE, pulse start_load, then load 16'h00AA then the terminator -> core_run drops, overflow clears, and 16'h00AA is written at address 0 with word_count = 1.
6. start_load pulsed during COLLECT and during WRITE -> no effect on mem_addr, word_count or nibble alignment.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg : shared state encoding and terminator word for the IRAM loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [15:0] C_END_WORD = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/nibble_packer.sv
// ---------------------------------------------------------------------------
// nibble_packer : MSB-first nibble shift register with a wrap-around counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nibble_packer #(
  parameter int DATA_W = 16,
  parameter int NIB_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [NIB_W-1:0]  nib_in,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  localparam int C_NIBS = DATA_W / NIB_W;
  localparam int C_CNT_W = (C_NIBS > 1) ? $clog2(C_NIBS) : 1;

  logic [DATA_W-1:0]  r_shift;
  logic [C_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  w_word;

  // Exposes the word as it will look once the current nibble is shifted in,
  // so the loader can act on the completing nibble in the same cycle.
  assign w_word    = {r_shift[DATA_W-NIB_W-1:0], nib_in};
  assign word      = w_word;
  assign word_full = shift_en && (r_cnt == C_CNT_W'(C_NIBS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (shift_en) begin
      r_shift <= w_word;
      r_cnt   <= word_full ? '0 : r_cnt + C_CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/iram_loader.sv
// ---------------------------------------------------------------------------
// iram_loader : assembles switch nibbles into words and boot-loads the IRAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iram_loader
  import loader_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                NIB_W    = 4,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] END_WORD = DATA_W'(C_END_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic [NIB_W-1:0]  nib_in,
  input  logic              nib_valid,
  output logic              nib_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_run,
  output logic [ADDR_W-1:0] word_count,
  output logic              overflow
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ovf;

  logic              w_ready;
  logic              w_accept;
  logic              w_clear;
  logic [DATA_W-1:0] w_word;
  logic              w_word_full;
  logic              w_is_end;
  logic [ADDR_W:0]   w_addr_inc;
  logic              w_at_depth;

  assign w_ready    = (r_state == ST_COLLECT);
  assign w_accept   = nib_valid && w_ready;
  assign w_clear    = start_load && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_is_end   = (w_word == END_WORD);
  // One extra bit so DEPTH == 2**ADDR_W is still detected.
  assign w_addr_inc = {1'b0, r_addr} + (ADDR_W + 1)'(1);
  assign w_at_depth = (w_addr_inc == (ADDR_W + 1)'(DEPTH));

  nibble_packer #(
    .DATA_W (DATA_W),
    .NIB_W  (NIB_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .shift_en  (w_accept),
    .nib_in    (nib_in),
    .word      (w_word),
    .word_full (w_word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start_load) w_next = ST_COLLECT;
      ST_COLLECT: if (w_word_full) w_next = w_is_end ? ST_DONE : ST_WRITE;
      ST_WRITE:   w_next = w_at_depth ? ST_DONE : ST_COLLECT;
      ST_DONE:    if (start_load) w_next = ST_COLLECT;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_count <= '0;
      r_wdata <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_clear) begin
        r_addr  <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end
      if (w_word_full && !w_is_end) begin
        r_wdata <= w_word;
      end
      if (r_state == ST_WRITE) begin
        r_addr  <= w_addr_inc[ADDR_W-1:0];
        r_count <= r_count + ADDR_W'(1);
        if (w_at_depth) r_ovf <= 1'b1;
      end
    end
  end

  assign nib_ready  = w_ready;
  assign mem_wr_en  = (r_state == ST_WRITE);
  assign core_run   = (r_state == ST_DONE);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign word_count = r_count;
  assign overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_iram_loader.sv
// ---------------------------------------------------------------------------
// tb_iram_loader : scoreboard bench for iram_loader (DEPTH 256 and DEPTH 4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_load;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        sel;

  logic        m_rdy, m_wr, m_run, m_ovf;
  logic [15:0] m_addr, m_wdata, m_cnt;
  logic        s_rdy, s_wr, s_run, s_ovf;
  logic [15:0] s_addr, s_wdata, s_cnt;

  logic        rdy, wr, run, ovf;
  logic [15:0] addr, wdata, cnt;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];
  logic [15:0] exp_addr;
  logic        prev_wr = 1'b0;

  always #5 clk = ~clk;

  iram_loader #(.DEPTH(256)) u_main (
    .clk(clk), .reset(reset), .start_load(start_load), .nib_in(nib_in),
    .nib_valid(nib_valid), .nib_ready(m_rdy), .mem_wr_en(m_wr),
    .mem_addr(m_addr), .mem_wdata(m_wdata), .core_run(m_run),
    .word_count(m_cnt), .overflow(m_ovf)
  );

  iram_loader #(.DEPTH(4)) u_small (
    .clk(clk), .reset(reset), .start_load(start_load), .nib_in(nib_in),
    .nib_valid(nib_valid), .nib_ready(s_rdy), .mem_wr_en(s_wr),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .core_run(s_run),
    .word_count(s_cnt), .overflow(s_ovf)
  );

  assign rdy   = sel ? s_rdy   : m_rdy;
  assign wr    = sel ? s_wr    : m_wr;
  assign run   = sel ? s_run   : m_run;
  assign ovf   = sel ? s_ovf   : m_ovf;
  assign addr  = sel ? s_addr  : m_addr;
  assign wdata = sel ? s_wdata : m_wdata;
  assign cnt   = sel ? s_cnt   : m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr) begin
      chk("wr_run_excl", {31'd0, run}, 32'd0);
      chk("wr_one_cycle", {31'd0, prev_wr}, 32'd0);
      chk("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("wr_addr", {16'd0, addr}, {16'd0, e[31:16]});
        chk("wr_data", {16'd0, wdata}, {16'd0, e[15:0]});
      end
    end
    prev_wr = wr;
  end

  task automatic send_nib(input logic [3:0] n);
    bit done = 0;
    nib_in    = n;
    nib_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (rdy) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("nib_timeout", 32'd0, 32'd1);
  endtask

  // Leaves nib_valid high so the next word's first nibble waits through WRITE.
  task automatic send_word(input logic [15:0] w);
    bit is_wr;
    is_wr = (w != 16'hFFFF);
    if (is_wr) sb_q.push_back({exp_addr, w});
    for (int i = 0; i < 4; i++) send_nib(w[15-4*i -: 4]);
    if (is_wr) begin
      chk("wr_latency", {31'd0, wr}, 32'd1);
      chk("rdy_in_write", {31'd0, rdy}, 32'd0);
      exp_addr++;
    end
  endtask

  task automatic do_start();
    nib_valid  = 1'b0;
    start_load = 1'b1;
    @(posedge clk);
    #1;
    start_load = 1'b0;
    exp_addr   = 16'd0;
  endtask

  task automatic do_reset();
    nib_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, {31'd0, rdy}, 32'd0);
    chk({tag, "_wr"},  {31'd0, wr},  32'd0);
    chk({tag, "_run"}, {31'd0, run}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    chk({tag, "_addr"}, {16'd0, addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, wdata}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, cnt}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_cnt;
    logic        exp_run;
  } vec_t;

  initial begin
    vec_t vecs[4];
    // word_count is sampled in the cycle right after the last nibble,
    // i.e. before the WRITE-cycle increment lands.
    vecs[0] = '{16'h1234, 16'd0, 1'b0};
    vecs[1] = '{16'hABCD, 16'd1, 1'b0};
    vecs[2] = '{16'h0000, 16'd2, 1'b0};
    vecs[3] = '{16'hFFFF, 16'd3, 1'b1};

    reset = 1'b1; start_load = 1'b0; nib_in = 4'd0; nib_valid = 1'b0;
    sel = 1'b0; exp_addr = 16'd0;
    #2;
    chk_zero("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Main load with nib_valid held high across every WRITE cycle.
    do_start();
    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v].word);
      chk("tbl_cnt", {16'd0, cnt}, {16'd0, vecs[v].exp_cnt});
      chk("tbl_run", {31'd0, run}, {31'd0, vecs[v].exp_run});
    end
    nib_valid = 1'b0;
    chk("tbl_ovf", {31'd0, ovf}, 32'd0);

    // start_load during COLLECT and during WRITE must be ignored.
    do_start();
    send_nib(4'h5);
    send_nib(4'h6);
    nib_valid = 1'b0;
    start_load = 1'b1;
    @(posedge clk);
    #1;
    start_load = 1'b0;
    sb_q.push_back({16'd0, 16'h5678});
    send_nib(4'h7);
    send_nib(4'h8);
    chk("s6_wr", {31'd0, wr}, 32'd1);
    nib_valid  = 1'b0;
    start_load = 1'b1;
    @(posedge clk);
    #1;
    start_load = 1'b0;
    chk("s6_cnt", {16'd0, cnt}, 32'd1);
    chk("s6_addr", {16'd0, addr}, 32'd1);
    chk("s6_rdy", {31'd0, rdy}, 32'd1);
    exp_addr = 16'd1;
    send_word(16'h9ABC);
    send_word(16'hFFFF);
    nib_valid = 1'b0;
    chk("s6_final_cnt", {16'd0, cnt}, 32'd2);

    // Reset mid-COLLECT: everything back to zero, no stale nibbles.
    do_start();
    send_nib(4'hE);
    send_nib(4'hE);
    nib_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_zero("rst_collect");
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_start();
    send_word(16'h1234);
    send_word(16'hFFFF);
    nib_valid = 1'b0;
    chk("rst_reload_cnt", {16'd0, cnt}, 32'd1);

    // Reset during WRITE cuts the strobe immediately.
    do_start();
    for (int i = 0; i < 4; i++) send_nib(4'h4 - 4'(i));
    nib_valid = 1'b0;
    chk("rstw_wr_pre", {31'd0, wr}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw_wr_cut", {31'd0, wr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Overflow on the DEPTH=4 instance.
    sel = 1'b1;
    do_reset();
    chk_zero("small_reset");
    do_start();
    for (int i = 1; i <= 4; i++) send_word(16'(i) * 16'h1111);
    @(posedge clk);
    #1;
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    chk("ovf_cnt", {16'd0, cnt}, 32'd4);
    chk("ovf_addr", {16'd0, addr}, 32'd4);
    chk("ovf_run", {31'd0, run}, 32'd1);
    nib_in = 4'h5;
    nib_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("ovf_rdy", {31'd0, rdy}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("ovf_cnt_hold", {16'd0, cnt}, 32'd4);

    // Reload from DONE clears core_run and overflow.
    do_start();
    chk("reload_run", {31'd0, run}, 32'd0);
    chk("reload_ovf", {31'd0, ovf}, 32'd0);
    chk("reload_cnt", {16'd0, cnt}, 32'd0);
    send_word(16'h00AA);
    send_word(16'hFFFF);
    nib_valid = 1'b0;
    chk("reload_done_run", {31'd0, run}, 32'd1);
    chk("reload_done_cnt", {16'd0, cnt}, 32'd1);
    chk("reload_done_ovf", {31'd0, ovf}, 32'd0);

    @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
